tl_rx_mst_req_dispatcher: RTL
=============================

TL_RX_MST_REQ_DISPATCHER -- requirements
Module: tl_rx_mst_req_dispatcher

Interface
REQ-001 Parameters: DW=32 (DW bits); ADDR_WIDTH=64; TAG_WIDTH=10; PAYLOAD_LENGTH=10 (TLP length field); VALID_DATA_WIDTH=5; BEAT_SIZE=32*DW; LEN_WIDTH=8 (AXI AxLEN).
REQ-002 One clock; reset is asynchronous and active-high: i_clk input 1 (rising edge), i_rst input 1 (asynchronous, active-high).
REQ-003 i_req_valid  in  1  request header present from read handler.
REQ-004 i_req_type  in  2  00 MRd, 01 MWr, 10 IORd, 11 IOWr.
REQ-005 i_req_address  in  ADDR_WIDTH  byte address; i_req_tag  in  TAG_WIDTH  request tag.
REQ-006 i_req_length  in  PAYLOAD_LENGTH  length in DW, 0 means 1024.
REQ-007 i_req_first_byte_enable, i_req_last_byte_enable  in  4 each  TLP byte enables.
REQ-008 i_req_data_write_inc  in  1  write data beat strobe; i_req_last  in  1  last beat marker.
REQ-009 i_req_valid_data  in  VALID_DATA_WIDTH  valid DW count minus 1; i_req_data  in  BEAT_SIZE  beat data, DW0 in bits [31:0].
REQ-010 o_AWREADY_fifo, o_WREADY_fifo, o_ARREADY_fifo  out  1 each  readiness returned to read handler.
REQ-011 i_aw_fifo_full, i_w_fifo_full, i_ar_fifo_full  in  1 each  downstream FIFO full flags.
REQ-012 o_ar_push, o_aw_push  out  1 each  single-cycle FIFO write strobes.
REQ-013 o_ax_addr  out  ADDR_WIDTH; o_ax_len  out  LEN_WIDTH; o_ax_id  out  TAG_WIDTH  shared AR/AW entry fields.
REQ-014 o_w_push  out  1; o_w_data  out  BEAT_SIZE; o_w_strb  out  BEAT_SIZE/8; o_w_last  out  1  W FIFO entry.
REQ-015 o_err_beat_mismatch  out  1  single-cycle protocol error pulse.

Function
REQ-016 FSM states: IDLE, WDATA; all outputs registered; read/write = i_req_type[0] 0/1.
REQ-017 IDLE: o_ARREADY_fifo = ~i_ar_fifo_full, o_AWREADY_fifo = ~i_aw_fifo_full, o_WREADY_fifo = 0; WDATA: o_WREADY_fifo = ~i_w_fifo_full, others 0 (combinational).
REQ-018 Header accepted when i_req_valid and matching ready high; i_req_valid otherwise ignored, no state change.
REQ-019 Beats = ceil(L/32), L = i_req_length (0 -> 1024), range 1..32; o_ax_len = beats-1, zero-extended; IO types forced o_ax_len = 0.
REQ-020 o_ax_addr = i_req_address unchanged; o_ax_id = i_req_tag.
REQ-021 Accepted read: o_ar_push = 1 exactly one cycle later with fields; stays IDLE; back-to-back reads accepted every cycle.
REQ-022 Accepted write: o_aw_push = 1 one cycle later; state -> WDATA; beat counter loaded with o_ax_len; L and byte enables captured.
REQ-023 WDATA beat accepted when i_req_data_write_inc and ~i_w_fifo_full: next cycle o_w_push = 1, o_w_data = registered i_req_data.
REQ-024 o_w_strb: bytes of DW0..DW(i_req_valid_data) = 1, others 0; first beat DW0 bytes = first_byte_enable; last beat last valid DW bytes = last_byte_enable unless L = 1 (first_byte_enable only).
REQ-025 Counter decrements per accepted beat; beat with counter = 0 gives o_w_last = 1, state -> IDLE.
REQ-026 i_req_last = 1 while counter != 0: beat pushed with o_w_last = 1, state -> IDLE, o_err_beat_mismatch pulses with the push.
REQ-027 Counter = 0 and i_req_last = 0: beat pushed with o_w_last = 1, IDLE, error pulse.
REQ-028 i_req_data_write_inc while i_w_fifo_full or in IDLE: beat dropped, no push, error pulse next cycle.
REQ-029 Pushes are 1-cycle pulses; field outputs hold last value between pushes.
REQ-030 Full flag rising in the same cycle as an accepted request does not cancel it; acceptance samples the flag at that edge only.

Reset
REQ-031 i_rst high asynchronously forces IDLE, counter 0, all registered outputs 0; mid-burst reset abandons burst, no o_w_last emitted.
REQ-032 First acceptance possible on the first rising edge after i_rst deasserts.

Verification
REQ-033 MRd L=64, addr 0x1000, tag 5 -> next cycle o_ar_push=1, o_ax_len=1, o_ax_addr=0x1000, o_ax_id=5.
REQ-034 MWr L=0 -> o_ax_len=31; 32 beats with i_req_last on 32nd -> 32 o_w_push, o_w_last only on 32nd, no error.
REQ-035 MWr L=1, first_be=4'b0110, valid_data=0 -> o_w_strb=...0110, o_w_last=1, back to IDLE.
REQ-036 MWr L=96, i_req_last on beat 2 -> beat 2 o_w_last=1, o_err_beat_mismatch=1, IDLE; i_w_fifo_full held -> o_WREADY_fifo=0, strobe dropped, error pulse.
REQ-037 i_rst asserted mid-WDATA beat 5 of 10 -> outputs 0 immediately; next MRd accepted normally after release.

Source files
------------

// File: rtl/tl_rx_mst_req_dispatcher.sv
// Turns TLP request headers from the read handler into AXI AR/AW FIFO entries
// and converts write payload beats into W FIFO entries with byte strobes.
module tl_rx_mst_req_dispatcher #(
  parameter int DW               = 32,
  parameter int ADDR_WIDTH       = 64,
  parameter int TAG_WIDTH        = 10,
  parameter int PAYLOAD_LENGTH   = 10,
  parameter int VALID_DATA_WIDTH = 5,
  parameter int BEAT_SIZE        = 32 * DW,
  parameter int LEN_WIDTH        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req_valid,
  input  logic [1:0]                  i_req_type,
  input  logic [ADDR_WIDTH-1:0]       i_req_address,
  input  logic [TAG_WIDTH-1:0]        i_req_tag,
  input  logic [PAYLOAD_LENGTH-1:0]   i_req_length,
  input  logic [3:0]                  i_req_first_byte_enable,
  input  logic [3:0]                  i_req_last_byte_enable,
  input  logic                        i_req_data_write_inc,
  input  logic                        i_req_last,
  input  logic [VALID_DATA_WIDTH-1:0] i_req_valid_data,
  input  logic [BEAT_SIZE-1:0]        i_req_data,
  output logic                        o_AWREADY_fifo,
  output logic                        o_WREADY_fifo,
  output logic                        o_ARREADY_fifo,
  input  logic                        i_aw_fifo_full,
  input  logic                        i_w_fifo_full,
  input  logic                        i_ar_fifo_full,
  output logic                        o_ar_push,
  output logic                        o_aw_push,
  output logic [ADDR_WIDTH-1:0]       o_ax_addr,
  output logic [LEN_WIDTH-1:0]        o_ax_len,
  output logic [TAG_WIDTH-1:0]        o_ax_id,
  output logic                        o_w_push,
  output logic [BEAT_SIZE-1:0]        o_w_data,
  output logic [BEAT_SIZE/8-1:0]      o_w_strb,
  output logic                        o_w_last,
  output logic                        o_err_beat_mismatch
);

  localparam int STRB_W = BEAT_SIZE / 8;
  localparam int NDW    = BEAT_SIZE / 32;

  typedef enum logic {S_IDLE = 1'b0, S_WDATA = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    single_dw_q, single_dw_d;
  logic [3:0]              fbe_q, fbe_d, lbe_q, lbe_d;
  logic                    ar_push_q, ar_push_d, aw_push_q, aw_push_d;
  logic [ADDR_WIDTH-1:0]   ax_addr_q, ax_addr_d;
  logic [LEN_WIDTH-1:0]    ax_len_q, ax_len_d;
  logic [TAG_WIDTH-1:0]    ax_id_q, ax_id_d;
  logic                    w_push_q, w_push_d, w_last_q, w_last_d;
  logic [BEAT_SIZE-1:0]    w_data_q, w_data_d;
  logic [STRB_W-1:0]       w_strb_q, w_strb_d;
  logic                    err_q, err_d;

  logic [PAYLOAD_LENGTH:0] len_eff_s, beats_m1_s;
  logic [LEN_WIDTH-1:0]    ax_len_s;
  logic                    rd_acc_s, wr_acc_s, beat_acc_s, beat_last_s, beat_err_s;

  // Valid DWs get full strobes; first DW takes first_be, last valid DW of the
  // final beat takes last_be unless the whole transfer is a single DW.
  function automatic logic [STRB_W-1:0] calc_strb(
    input logic [VALID_DATA_WIDTH-1:0] vd,
    input logic first, input logic last, input logic single,
    input logic [3:0] fbe, input logic [3:0] lbe);
    logic [STRB_W-1:0] s;
    s = '0;
    for (int k = 0; k < NDW; k++) begin
      if (k <= int'(vd)) s[4*k +: 4] = 4'hF;
      else               s[4*k +: 4] = 4'h0;
    end
    if (last && !single) s[4*int'(vd) +: 4] = lbe;
    if (first)           s[3:0] = fbe;
    return s;
  endfunction

  assign o_ARREADY_fifo = (state_q == S_IDLE)  & ~i_ar_fifo_full;
  assign o_AWREADY_fifo = (state_q == S_IDLE)  & ~i_aw_fifo_full;
  assign o_WREADY_fifo  = (state_q == S_WDATA) & ~i_w_fifo_full;

  // A zero length field encodes the maximum payload of 1024 DW.
  assign len_eff_s   = {(i_req_length == '0), i_req_length};
  assign beats_m1_s  = (len_eff_s - (PAYLOAD_LENGTH+1)'(1)) >> 5;
  assign ax_len_s    = i_req_type[1] ? '0 : LEN_WIDTH'(beats_m1_s);

  assign rd_acc_s    = i_req_valid & ~i_req_type[0] & o_ARREADY_fifo;
  assign wr_acc_s    = i_req_valid &  i_req_type[0] & o_AWREADY_fifo;
  assign beat_acc_s  = (state_q == S_WDATA) & i_req_data_write_inc & ~i_w_fifo_full;
  assign beat_last_s = (cnt_q == '0) | i_req_last;
  assign beat_err_s  = ((cnt_q != '0) & i_req_last) | ((cnt_q == '0) & ~i_req_last);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    single_dw_d = single_dw_q;
    fbe_d       = fbe_q;
    lbe_d       = lbe_q;
    ar_push_d   = 1'b0;
    aw_push_d   = 1'b0;
    ax_addr_d   = ax_addr_q;
    ax_len_d    = ax_len_q;
    ax_id_d     = ax_id_q;
    w_push_d    = 1'b0;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    w_last_d    = 1'b0;
    err_d       = i_req_data_write_inc & ~beat_acc_s;
    case (state_q)
      S_IDLE: begin
        if (rd_acc_s || wr_acc_s) begin
          ar_push_d = rd_acc_s;
          aw_push_d = wr_acc_s;
          ax_addr_d = i_req_address;
          ax_len_d  = ax_len_s;
          ax_id_d   = i_req_tag;
        end else begin
          ax_addr_d = ax_addr_q;
        end
        if (wr_acc_s) begin
          state_d     = S_WDATA;
          cnt_d       = ax_len_s;
          first_d     = 1'b1;
          single_dw_d = (len_eff_s == (PAYLOAD_LENGTH+1)'(1));
          fbe_d       = i_req_first_byte_enable;
          lbe_d       = i_req_last_byte_enable;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (beat_acc_s) begin
          w_push_d = 1'b1;
          w_data_d = i_req_data;
          w_strb_d = calc_strb(i_req_valid_data, first_q, beat_last_s, single_dw_q,
                               fbe_q, lbe_q);
          w_last_d = beat_last_s;
          err_d    = beat_err_s;
          first_d  = 1'b0;
          if (beat_last_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      single_dw_q <= 1'b0;
      fbe_q       <= 4'h0;
      lbe_q       <= 4'h0;
      ar_push_q   <= 1'b0;
      aw_push_q   <= 1'b0;
      ax_addr_q   <= '0;
      ax_len_q    <= '0;
      ax_id_q     <= '0;
      w_push_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      w_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      single_dw_q <= single_dw_d;
      fbe_q       <= fbe_d;
      lbe_q       <= lbe_d;
      ar_push_q   <= ar_push_d;
      aw_push_q   <= aw_push_d;
      ax_addr_q   <= ax_addr_d;
      ax_len_q    <= ax_len_d;
      ax_id_q     <= ax_id_d;
      w_push_q    <= w_push_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      w_last_q    <= w_last_d;
      err_q       <= err_d;
    end
  end

  assign o_ar_push           = ar_push_q;
  assign o_aw_push           = aw_push_q;
  assign o_ax_addr           = ax_addr_q;
  assign o_ax_len            = ax_len_q;
  assign o_ax_id             = ax_id_q;
  assign o_w_push            = w_push_q;
  assign o_w_data            = w_data_q;
  assign o_w_strb            = w_strb_q;
  assign o_w_last            = w_last_q;
  assign o_err_beat_mismatch = err_q;

endmodule
